// File: rtl/bus_controller.sv
// Two-master bus sequencer: fixed priority to master 1 with a starvation guard
// for master 2, registered slave-side strobes, timeout abort and done/err pulses.
module bus_controller #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int TIMEOUT      = 15,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m2_read,
   input  logic              m2_write,
   input  logic [ADDR_W-1:0] m2_addr,
   input  logic [DATA_W-1:0] m2_wdata,
   output logic              grant1,
   output logic              grant2,
   output logic              m1_done,
   output logic              m2_done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_rd,
   output logic              bus_wr,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic              busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   logic [1:0]        state_r;
   logic [TMR_W-1:0]  timer_r;
   logic [STV_W-1:0]  starve_cnt_r;
   logic              op_wr_r;
   logic              grant1_r;
   logic              grant2_r;
   logic              m1_done_r;
   logic              m2_done_r;
   logic              err_r;
   logic [DATA_W-1:0] rdata_r;
   logic [ADDR_W-1:0] bus_addr_r;
   logic [DATA_W-1:0] bus_wdata_r;
   logic              bus_rd_r;
   logic              bus_wr_r;
   logic              busy_r;

   logic              m1_req_s;
   logic              m2_req_s;
   logic              pick_m2_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              sel_wr_s;
   logic [STV_W-1:0]  starve_nxt_s;

   // Arbitration: winner, its latched fields and the next starvation count.
   always_comb begin
      m1_req_s = m1_read | m1_write;
      m2_req_s = m2_read | m2_write;

      if (m2_req_s && (!m1_req_s || (starve_cnt_r == STV_MAX))) begin
         pick_m2_s = 1'b1;
      end else begin
         pick_m2_s = 1'b0;
      end

      // Read+write together is a write, hence the write bit alone decides the op.
      if (pick_m2_s) begin
         sel_addr_s  = m2_addr;
         sel_wdata_s = m2_wdata;
         sel_wr_s    = m2_write;
      end else begin
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
         sel_wr_s    = m1_write;
      end

      if (pick_m2_s || !m2_req_s) begin
         starve_nxt_s = '0;
      end else if (starve_cnt_r == STV_MAX) begin
         starve_nxt_s = starve_cnt_r;
      end else begin
         starve_nxt_s = starve_cnt_r + STV_W'(1);
      end
   end

   // Transaction sequencer and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         timer_r      <= '0;
         starve_cnt_r <= '0;
         op_wr_r      <= 1'b0;
         grant1_r     <= 1'b0;
         grant2_r     <= 1'b0;
         m1_done_r    <= 1'b0;
         m2_done_r    <= 1'b0;
         err_r        <= 1'b0;
         rdata_r      <= '0;
         bus_addr_r   <= '0;
         bus_wdata_r  <= '0;
         bus_rd_r     <= 1'b0;
         bus_wr_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               m1_done_r <= 1'b0;
               m2_done_r <= 1'b0;
               err_r     <= 1'b0;
               if (m1_req_s || m2_req_s) begin
                  state_r      <= ST_ACCESS;
                  timer_r      <= '0;
                  starve_cnt_r <= starve_nxt_s;
                  op_wr_r      <= sel_wr_s;
                  grant1_r     <= ~pick_m2_s;
                  grant2_r     <= pick_m2_s;
                  bus_addr_r   <= sel_addr_s;
                  bus_wdata_r  <= sel_wdata_s;
                  bus_rd_r     <= ~sel_wr_s;
                  bus_wr_r     <= sel_wr_s;
                  busy_r       <= 1'b1;
               end
            end
            ST_ACCESS: begin
               if (bus_ready || (timer_r == TMR_LAST)) begin
                  state_r   <= ST_DONE;
                  bus_rd_r  <= 1'b0;
                  bus_wr_r  <= 1'b0;
                  m1_done_r <= grant1_r;
                  m2_done_r <= grant2_r;
                  err_r     <= ~bus_ready;
                  if (bus_ready && !op_wr_r) begin
                     rdata_r <= bus_rdata;
                  end
               end else begin
                  timer_r <= timer_r + TMR_W'(1);
               end
            end
            ST_DONE: begin
               state_r   <= ST_IDLE;
               grant1_r  <= 1'b0;
               grant2_r  <= 1'b0;
               m1_done_r <= 1'b0;
               m2_done_r <= 1'b0;
               err_r     <= 1'b0;
               busy_r    <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               grant1_r  <= 1'b0;
               grant2_r  <= 1'b0;
               m1_done_r <= 1'b0;
               m2_done_r <= 1'b0;
               err_r     <= 1'b0;
               bus_rd_r  <= 1'b0;
               bus_wr_r  <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign grant1    = grant1_r;
   assign grant2    = grant2_r;
   assign m1_done   = m1_done_r;
   assign m2_done   = m2_done_r;
   assign err       = err_r;
   assign rdata     = rdata_r;
   assign bus_addr  = bus_addr_r;
   assign bus_wdata = bus_wdata_r;
   assign bus_rd    = bus_rd_r;
   assign bus_wr    = bus_wr_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bus_controller;

   localparam int TIMEOUT      = 15;
   localparam int STARVE_LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        m1_read, m1_write, m2_read, m2_write;
   logic [15:0] m1_addr, m2_addr;
   logic [7:0]  m1_wdata, m2_wdata;
   logic        grant1, grant2, m1_done, m2_done, err;
   logic [7:0]  rdata;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_rd, bus_wr;
   logic [7:0]  bus_rdata;
   logic        bus_ready;
   logic        busy;

   bus_controller #(
      .ADDR_W(16), .DATA_W(8), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m2_read(m2_read), .m2_write(m2_write), .m2_addr(m2_addr), .m2_wdata(m2_wdata),
      .grant1(grant1), .grant2(grant2), .m1_done(m1_done), .m2_done(m2_done),
      .err(err), .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_rdata(bus_rdata),
      .bus_ready(bus_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model state: current transaction phase and expected outputs.
   int         m_phase  = 0;   // 0 no transaction, 1 on the bus, 2 completion cycle
   int         m_age    = 0;
   int         m_owner  = 0;
   int         m_streak = 0;
   bit         m_wr     = 1'b0;
   bit         r1, r2, m2win;
   logic       exp_grant1 = 1'b0, exp_grant2 = 1'b0, exp_m1_done = 1'b0, exp_m2_done = 1'b0;
   logic       exp_err = 1'b0, exp_bus_rd = 1'b0, exp_bus_wr = 1'b0, exp_busy = 1'b0;
   logic [7:0]  exp_rdata = 8'h00, exp_bus_wdata = 8'h00;
   logic [15:0] exp_bus_addr = 16'h0000;
   int         mdl_win[$];
   int         dut_win[$];

   task automatic mdl_finish(input bit e);
      exp_bus_rd = 1'b0;
      exp_bus_wr = 1'b0;
      exp_err    = e;
      if (m_owner == 1) exp_m1_done = 1'b1;
      else              exp_m2_done = 1'b1;
      m_phase = 2;
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) begin
         exp_grant1 = 1'b0; exp_grant2 = 1'b0; exp_m1_done = 1'b0; exp_m2_done = 1'b0;
         exp_err = 1'b0; exp_bus_rd = 1'b0; exp_bus_wr = 1'b0; exp_busy = 1'b0;
         exp_rdata = 8'h00; exp_bus_addr = 16'h0000; exp_bus_wdata = 8'h00;
         m_phase = 0; m_streak = 0;
         chk_en = 1'b1;
      end else if (m_phase == 2) begin
         exp_grant1 = 1'b0; exp_grant2 = 1'b0; exp_m1_done = 1'b0; exp_m2_done = 1'b0;
         exp_err = 1'b0; exp_busy = 1'b0;
         m_phase = 0;
      end else if (m_phase == 1) begin
         if (bus_ready) begin
            if (!m_wr) exp_rdata = bus_rdata;
            mdl_finish(1'b0);
         end else if (m_age == TIMEOUT - 1) begin
            mdl_finish(1'b1);
         end else begin
            m_age++;
         end
      end else begin
         r1 = m1_read | m1_write;
         r2 = m2_read | m2_write;
         if (r1 || r2) begin
            m2win = r2 && (!r1 || (m_streak == STARVE_LIMIT));
            if (m2win || !r2)               m_streak = 0;
            else if (m_streak < STARVE_LIMIT) m_streak++;
            m_owner       = m2win ? 2 : 1;
            m_wr          = m2win ? m2_write : m1_write;
            exp_bus_addr  = m2win ? m2_addr : m1_addr;
            exp_bus_wdata = m2win ? m2_wdata : m1_wdata;
            exp_grant1    = !m2win;
            exp_grant2    = m2win;
            exp_bus_rd    = !m_wr;
            exp_bus_wr    = m_wr;
            exp_busy      = 1'b1;
            m_age         = 0;
            m_phase       = 1;
            mdl_win.push_back(m_owner);
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("grant1",     32'(grant1),    32'(exp_grant1));
         chk("grant2",     32'(grant2),    32'(exp_grant2));
         chk("m1_done",    32'(m1_done),   32'(exp_m1_done));
         chk("m2_done",    32'(m2_done),   32'(exp_m2_done));
         chk("err",        32'(err),       32'(exp_err));
         chk("rdata",      32'(rdata),     32'(exp_rdata));
         chk("bus_addr",   32'(bus_addr),  32'(exp_bus_addr));
         chk("bus_wdata",  32'(bus_wdata), 32'(exp_bus_wdata));
         chk("bus_rd",     32'(bus_rd),    32'(exp_bus_rd));
         chk("bus_wr",     32'(bus_wr),    32'(exp_bus_wr));
         chk("busy",       32'(busy),      32'(exp_busy));
         chk("grant_excl", 32'(grant1 & grant2), 32'h0);
      end
   end

   // Slave and master-side responders: ready after slv_delay strobe cycles, drop request on done.
   int         slv_delay = -1;
   int         acc_cnt   = 0;
   logic [7:0] slv_data  = 8'h00;
   bit         m1_hold   = 1'b0;
   logic       pg1 = 1'b0, pg2 = 1'b0;

   initial forever begin
      @(negedge clk);
      if (bus_rd || bus_wr) acc_cnt = acc_cnt + 1;
      else                  acc_cnt = 0;
      bus_ready = (acc_cnt != 0) && (acc_cnt == slv_delay);
      bus_rdata = slv_data;
      if (grant1 && !pg1) dut_win.push_back(1);
      if (grant2 && !pg2) dut_win.push_back(2);
      pg1 = grant1;
      pg2 = grant2;
      if (m1_done && !m1_hold) begin m1_read = 1'b0; m1_write = 1'b0; end
      if (m2_done)             begin m2_read = 1'b0; m2_write = 1'b0; end
   end

   logic f_rd, f_g1;

   task automatic wait_done(input int who, input int max, input string nm,
                            output int nstb, output int ncyc);
      bit seen = 1'b0;
      nstb = 0;
      ncyc = 0;
      while (!seen && ncyc < max) begin
         @(negedge clk);
         ncyc++;
         if (bus_rd || bus_wr) nstb++;
         if (ncyc == 1) begin f_rd = bus_rd; f_g1 = grant1; end
         if ((who == 1) ? m1_done : m2_done) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no done within %0d cycles, required a done pulse", nm, max);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog");
   end

   int nstb, ncyc, base, n;

   initial begin
      rst = 1'b1;
      m1_read = 1'b1; m1_write = 1'b0; m1_addr = 16'h0040; m1_wdata = 8'h00;
      m2_read = 1'b0; m2_write = 1'b0; m2_addr = 16'h0000; m2_wdata = 8'h00;
      bus_ready = 1'b0; bus_rdata = 8'h00;
      slv_delay = 2; slv_data = 8'hA5;

      // Reset held two cycles with a pending read.
      repeat (2) begin
         @(negedge clk);
         chk("rst_flags", 32'({grant1, grant2, m1_done, m2_done, err, bus_rd, bus_wr, busy}), 32'h0);
         chk("rst_rdata", 32'(rdata), 32'h0);
         chk("rst_addr",  32'(bus_addr), 32'h0);
      end
      rst = 1'b0;

      // Single read, ready in the second access cycle.
      wait_done(1, 20, "single_read", nstb, ncyc);
      chk("first_bus_rd", 32'(f_rd), 32'h1);
      chk("first_grant1", 32'(f_g1), 32'h1);
      chk("read_strobes", nstb, 2);
      chk("read_latency", ncyc, 3);
      chk("read_rdata",   32'(rdata), 32'hA5);
      chk("read_err",     32'(err), 32'h0);
      @(negedge clk);
      chk("done_width",   32'(m1_done), 32'h0);

      // Timeout on a master-2 write with the slave never ready.
      m2_write = 1'b1; m2_addr = 16'h0300; m2_wdata = 8'hC3; slv_delay = -1;
      wait_done(2, 40, "timeout", nstb, ncyc);
      chk("to_err",     32'(err), 32'h1);
      chk("to_bus_wr",  32'(bus_wr), 32'h0);
      chk("to_rdata",   32'(rdata), 32'hA5);
      chk("to_strobes", nstb, 15);
      chk("to_latency", ncyc, 16);
      @(negedge clk);
      chk("to_err_width", 32'(err), 32'h0);

      // Contention: master 1 write and master 2 read together.
      base = dut_win.size();
      m1_write = 1'b1; m1_addr = 16'h1234; m1_wdata = 8'h5A;
      m2_read  = 1'b1; m2_addr = 16'h0200;
      slv_delay = 1; slv_data = 8'h3C;
      wait_done(2, 30, "contention", nstb, ncyc);
      chk("cont_count",  dut_win.size() - base, 2);
      chk("cont_first",  dut_win[base], 1);
      chk("cont_second", dut_win[base + 1], 2);
      chk("cont_model",  mdl_win[base * 0 + mdl_win.size() - 2], 1);
      chk("cont_cycles", ncyc, 5);
      chk("cont_rdata",  32'(rdata), 32'h3C);
      @(negedge clk);

      // Starvation guard: master 1 continuous, master 2 waiting.
      base = dut_win.size();
      n = mdl_win.size();
      m1_hold = 1'b1; m1_read = 1'b1; m1_addr = 16'h0010;
      m2_read = 1'b1; m2_addr = 16'h0020;
      slv_delay = 1; slv_data = 8'h11;
      wait_done(2, 40, "starve", nstb, ncyc);
      m1_hold = 1'b0;
      chk("starve_cycles", ncyc, 11);
      wait_done(1, 20, "starve_tail", nstb, ncyc);
      chk("starve_w0", dut_win[base],     1);
      chk("starve_w1", dut_win[base + 1], 1);
      chk("starve_w2", dut_win[base + 2], 1);
      chk("starve_w3", dut_win[base + 3], 2);
      chk("starve_m3", mdl_win[n + 3],    2);
      @(negedge clk);

      // Reset during the third access cycle, then a fresh read.
      m1_read = 1'b1; m1_addr = 16'h00F0; slv_delay = -1;
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         @(negedge clk);
         if (bus_rd) n++;
         if (n == 3) rst = 1'b1;
      end
      chk("mid_reached", n, 3);
      @(negedge clk);
      chk("mid_bus_rd", 32'(bus_rd), 32'h0);
      chk("mid_grant",  32'({grant1, grant2}), 32'h0);
      chk("mid_pulse",  32'({m1_done, m2_done, err}), 32'h0);
      chk("mid_busy",   32'(busy), 32'h0);
      rst = 1'b0; slv_delay = 2; slv_data = 8'h77;
      wait_done(1, 20, "after_reset", nstb, ncyc);
      chk("ar_latency", ncyc, 3);
      chk("ar_rdata",   32'(rdata), 32'h77);
      chk("ar_err",     32'(err), 32'h0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Transaction sequencer and arbiter for the internal MCU bus; sits between two bus masters (master 1, e.g. CPU; master 2, e.g. DMA/communication unit) and the shared slave-side bus.
- Arbitrates read/write requests with fixed priority to master 1, plus a starvation guard for master 2.
- Latches the winner's address, data and operation, and drives the bus until the slave is ready or a timeout occurs.
- Returns read data and a one-cycle done/error pulse to the requesting master.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- TIMEOUT, 15, maximum ACCESS cycles waiting for bus_ready before abort (must be >= 1).
- STARVE_LIMIT, 3, number of consecutive master-1 grants made while master 2 was waiting, after which master 2 wins the next contested arbitration.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- m1_read  input  1  master 1 read request; a level held until m1_done.
- m1_write  input  1  master 1 write request; a level held until m1_done.
- m1_addr  input  ADDR_W  master 1 address.
- m1_wdata  input  DATA_W  master 1 write data.
- m2_read, m2_write, m2_addr, m2_wdata  input  1/1/ADDR_W/DATA_W  same as the master 1 ports, for master 2.
- grant1  output  1  master 1 owns the bus.
- grant2  output  1  master 2 owns the bus.
- m1_done, m2_done  output  1  one-cycle completion pulse to the owning master.
- err  output  1  one-cycle pulse, coincident with done, when the transaction timed out.
- rdata  output  DATA_W  last successfully read data.
- bus_addr  output  ADDR_W  slave-side address.
- bus_wdata  output  DATA_W  slave-side write data.
- bus_rd  output  1  slave-side read strobe.
- bus_wr  output  1  slave-side write strobe.
- bus_rdata  input  DATA_W  slave read data, valid when bus_ready=1.
- bus_ready  input  1  slave has completed the access.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0: grants, dones, err, rdata, bus_addr, bus_wdata, bus_rd, bus_wr, busy. Timeout timer and starvation counter cleared.
- Reset asserted mid-transaction: transaction abandoned, no done/err pulse, all outputs 0 after that edge.
- Request decode: Mx = mx_read | mx_write. If a master asserts read and write together, it is treated as a write.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, any request: select a winner, latch its address, wdata and op, set its grant, go to ACCESS.
- Winner selection: M1 only → master 1. M2 only → master 2. Both → master 1, unless starve_cnt == STARVE_LIMIT, in which case master 2.
- starve_cnt update at each arbitration:
  - +1 when master 1 wins while M2=1, saturating at STARVE_LIMIT.
  - Cleared when master 2 wins or when M2=0.
- ACCESS: bus_rd or bus_wr = 1 per the latched op; bus_addr and bus_wdata are driven from the latches. Timer starts at 0 on entry.
  - bus_ready=1: for a read, rdata <= bus_rdata. Go to DONE, err=0.
  - bus_ready=0 and timer == TIMEOUT-1: go to DONE with err=1; rdata unchanged.
  - Otherwise: timer +1, stay in ACCESS.
- DONE (exactly one cycle):
  - mx_done=1 for the owner; err as decided in ACCESS.
  - bus_rd=bus_wr=0; grant still held.
  - Next state is IDLE, where grants drop to 0.
- Master contract: the master deasserts its request at the edge where it samples done=1, so IDLE does not see a stale request. A request still high in IDLE is a new transaction.
- Latency: request first seen in IDLE at cycle 0 → bus strobe in cycle 1 → ready in cycle k → done in cycle k+1. Minimum is done at cycle 2. Back-to-back transactions take 3 cycles each.
- Requests that change during ACCESS/DONE are ignored; the latched values are used.
- bus_addr and bus_wdata hold their last values when idle; only the strobes qualify them.

Test Plan:
- Reset then idle: hold rst for 2 cycles with m1_read=1 → all outputs 0 during reset; bus_rd=1, grant1=1 on the first cycle after release.
- Single read: m1_read, m1_addr=16'h0040, slave returns bus_rdata=8'hA5 with ready in the 2nd ACCESS cycle → m1_done pulse 1 cycle, rdata=8'hA5, err=0, bus_rd high exactly 2 cycles.
- Contention: m1_write and m2_read both held; each master drops its request on its done → master 1 served first, then master 2, with no overlap of grant1/grant2.
- Starvation: m1 requests continuously, m2_read held, STARVE_LIMIT=3, slave always ready → 3 master-1 transactions, then master 2 granted on the 4th arbitration, starve_cnt back to 0.
- Timeout: m2_write, bus_ready held 0 → after 15 ACCESS cycles, m2_done=1 and err=1 in the same cycle, rdata unchanged, bus_wr deasserted in DONE.
- Reset mid-access: rst asserted in the 3rd ACCESS cycle → bus_rd=0, grant=0 the next cycle, no done/err pulse; a fresh request afterwards completes normally.
